// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// decoder jump selects, opcode constants and the branch-offset helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RESET_WAIT = 2'd0,
    ST_FETCH      = 2'd1,
    ST_HOLD       = 2'd2
  } fetch_state_e;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JR   = 2'b10;
  localparam logic [1:0] JMP_RSVD = 2'b11;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sign-extended word offset of a branch immediate, as a byte offset
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jr, j/jal, taken branch or sequential.
// Also flags a jr whose target has nonzero low bits.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  jmp,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        jr_misaligned
);

  logic [31:0] pc_plus4_s;
  logic [31:0] branch_target_s;
  logic [31:0] next_pc_s;
  logic        branch_taken_s;
  logic        jr_sel_s;

  // Next-PC mux; a reserved jump select behaves like no jump
  always_comb begin
    pc_plus4_s      = pc + 32'd4;
    branch_target_s = pc_plus4_s + branch_offset(instr[15:0]);
    branch_taken_s  = branch & (zero ^ (instr[31:26] == OP_BNE));
    jr_sel_s        = 1'b0;
    next_pc_s       = pc_plus4_s;
    case (jmp)
      JMP_JR: begin
        next_pc_s = {jr_target[31:2], 2'b00};
        jr_sel_s  = 1'b1;
      end
      JMP_J: begin
        next_pc_s = {pc_plus4_s[31:28], instr[25:0], 2'b00};
      end
      JMP_NONE, JMP_RSVD: begin
        if (branch_taken_s) begin
          next_pc_s = branch_target_s;
        end else begin
          next_pc_s = pc_plus4_s;
        end
      end
      default: begin
        next_pc_s = pc_plus4_s;
      end
    endcase
  end

  assign pc_plus4      = pc_plus4_s;
  assign next_pc       = next_pc_s;
  assign jr_misaligned = jr_sel_s & (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: request/hold handshake with instruction memory and
// the execute stage, PC update on consume, sticky error flags, retire count.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter int          IMEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        ex_ready,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  input  logic [1:0]  Jmp,
  input  logic        Branch,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err,
  output logic        align_err,
  output logic [31:0] retired
);

  localparam int WAIT_W = $clog2(IMEM_WAIT_MAX + 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(IMEM_WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_SAT_C = {WAIT_W{1'b1}};

  fetch_state_e      state_r;
  logic [31:0]       pc_r;
  logic [31:0]       instr_r;
  logic              instr_valid_r;
  logic              imem_req_r;
  logic              fetch_err_r;
  logic              align_err_r;
  logic [31:0]       retired_r;
  logic [WAIT_W-1:0] wait_cnt_r;

  logic [31:0]       next_pc_s;
  logic [31:0]       pc_plus4_s;
  logic              jr_misaligned_s;

  next_pc_calc u_next_pc_calc (
    .pc            (pc_r),
    .instr         (instr_r),
    .jmp           (Jmp),
    .branch        (Branch),
    .zero          (zero),
    .jr_target     (jr_target),
    .pc_plus4      (pc_plus4_s),
    .next_pc       (next_pc_s),
    .jr_misaligned (jr_misaligned_s)
  );

  // Fetch FSM with all architectural state; imem_ready only matters in FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_RESET_WAIT;
      pc_r          <= RESET_PC;
      instr_r       <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      imem_req_r    <= 1'b0;
      fetch_err_r   <= 1'b0;
      align_err_r   <= 1'b0;
      retired_r     <= 32'h0000_0000;
      wait_cnt_r    <= '0;
    end else begin
      case (state_r)
        ST_RESET_WAIT: begin
          state_r    <= ST_FETCH;
          imem_req_r <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            instr_r       <= imem_rdata;
            instr_valid_r <= 1'b1;
            imem_req_r    <= 1'b0;
            wait_cnt_r    <= '0;
            state_r       <= ST_HOLD;
          end else begin
            // Counter saturates so a very long stall cannot wrap it
            if (wait_cnt_r != WAIT_SAT_C) begin
              wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
            end
            if (wait_cnt_r >= WAIT_MAX_C) begin
              fetch_err_r <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (ex_ready) begin
            pc_r          <= next_pc_s;
            retired_r     <= retired_r + 32'd1;
            instr_valid_r <= 1'b0;
            imem_req_r    <= 1'b1;
            state_r       <= ST_FETCH;
            if (jr_misaligned_s) begin
              align_err_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r       <= ST_RESET_WAIT;
          imem_req_r    <= 1'b0;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign opcode      = instr_r[31:26];
  assign func        = instr_r[5:0];
  assign pc          = pc_r;
  assign pc_plus4    = pc_plus4_s;
  assign fetch_err   = fetch_err_r;
  assign align_err   = align_err_r;
  assign retired     = retired_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: the bench plays instruction memory and
// decoder, predicts each next fetch address into a queue and compares on fetch.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ex_ready = 1'b0;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [1:0]  Jmp = 2'b00;
  logic        Branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] jr_target = 32'h0000_0000;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;
  logic        align_err;
  logic [31:0] retired;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] m_pc = 32'h0000_0000;
  logic [31:0] m_instr = 32'h0000_0000;
  logic [31:0] m_retired = 32'h0000_0000;
  logic        m_ferr = 1'b0;
  logic        m_aerr = 1'b0;

  fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .IMEM_WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .ex_ready    (ex_ready),
    .opcode      (opcode),
    .func        (func),
    .Jmp         (Jmp),
    .Branch      (Branch),
    .zero        (zero),
    .jr_target   (jr_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err),
    .align_err   (align_err),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] iw,
                                             input logic [1:0] j, input logic br, input logic z,
                                             input logic [31:0] jrt);
    logic [31:0] p4;
    logic        taken;
    p4    = cur_pc + 32'd4;
    taken = br & (z ^ (iw[31:26] == 6'b000101));
    if (j == 2'b10) return {jrt[31:2], 2'b00};
    if (j == 2'b01) return {p4[31:28], iw[25:0], 2'b00};
    if (taken) return p4 + {{14{iw[15]}}, iw[15:0], 2'b00};
    return p4;
  endfunction

  task automatic wait_fetch();
    int n = 0;
    while (!imem_req && n < 50) begin
      tick();
      n++;
    end
    check_eq("fetch_req_seen", 32'(imem_req), 32'd1);
  endtask

  task automatic pop_expected(output logic [31:0] ea);
    check_eq("sb_nonempty", 32'(exp_addr_q.size() > 0), 32'd1);
    if (exp_addr_q.size() > 0) ea = exp_addr_q.pop_front();
    else ea = 32'hDEAD_BEEF;
  endtask

  task automatic do_fetch(input logic [31:0] word, input int waits);
    logic [31:0] ea;
    wait_fetch();
    pop_expected(ea);
    check_eq("imem_addr", imem_addr, ea);
    m_pc = ea;
    for (int i = 1; i <= waits; i++) begin
      tick();
      if (i > WAIT_MAX) m_ferr = 1'b1;
      check_eq("stall_fetch_err", 32'(fetch_err), 32'(m_ferr));
      check_eq("stall_imem_req", 32'(imem_req), 32'd1);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'hA5A5_5A5A;
    m_instr = word;
    check_eq("hold_instr", instr, word);
    check_eq("hold_valid", 32'(instr_valid), 32'd1);
    check_eq("hold_req", 32'(imem_req), 32'd0);
    check_eq("hold_pc", pc, m_pc);
    check_eq("hold_pc_plus4", pc_plus4, m_pc + 32'd4);
    check_eq("hold_opcode", 32'(opcode), 32'(word[31:26]));
    check_eq("hold_func", 32'(func), 32'(word[5:0]));
    check_eq("hold_fetch_err", 32'(fetch_err), 32'(m_ferr));
  endtask

  task automatic do_consume(input logic [1:0] j, input logic br, input logic z, input logic [31:0] jrt);
    logic [31:0] exp_pc;
    exp_pc = model_next(m_pc, m_instr, j, br, z, jrt);
    if (j == 2'b10 && jrt[1:0] != 2'b00) m_aerr = 1'b1;
    Jmp = j;
    Branch = br;
    zero = z;
    jr_target = jrt;
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    Jmp = 2'b00;
    Branch = 1'b0;
    zero = 1'b0;
    jr_target = 32'h0000_0000;
    m_retired = m_retired + 32'd1;
    exp_addr_q.push_back(exp_pc);
    check_eq("consume_pc", pc, exp_pc);
    check_eq("consume_retired", retired, m_retired);
    check_eq("consume_valid", 32'(instr_valid), 32'd0);
    check_eq("consume_req", 32'(imem_req), 32'd1);
    check_eq("consume_align_err", 32'(align_err), 32'(m_aerr));
  endtask

  logic [31:0] j40_w;
  logic [31:0] beq_w;
  logic [31:0] bne_w;
  logic [31:0] ea_final;

  initial begin
    j40_w = {OP_J, 26'h000_0010};
    beq_w = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};
    bne_w = {OP_BNE, 5'd1, 5'd2, 16'hFFFE};

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_imem_req", 32'(imem_req), 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_pc", pc, 32'd0);
    check_eq("rst_retired", retired, 32'd0);
    check_eq("rst_fetch_err", 32'(fetch_err), 32'd0);
    check_eq("rst_align_err", 32'(align_err), 32'd0);
    exp_addr_q.push_back(32'h0000_0000);
    rst = 1'b1;

    // Straight-line code, zero-wait memory
    for (int k = 0; k < 3; k++) begin
      do_fetch(32'h0000_0020 + 32'(k), 0);
      do_consume(2'b00, 1'b0, 1'b0, 32'd0);
    end
    check_eq("seq_retired_3", retired, 32'd3);
    check_eq("seq_pc_12", pc, 32'h0000_000C);

    do_fetch(j40_w, 0);
    do_consume(2'b01, 1'b0, 1'b0, 32'd0);
    check_eq("j_to_40", pc, 32'h0000_0040);
    do_fetch(beq_w, 0);
    do_consume(2'b00, 1'b1, 1'b1, 32'd0);
    check_eq("beq_taken", pc, 32'h0000_003C);
    do_fetch(j40_w, 0);
    do_consume(2'b01, 1'b0, 1'b0, 32'd0);
    do_fetch(beq_w, 0);
    do_consume(2'b00, 1'b1, 1'b0, 32'd0);
    check_eq("beq_not_taken", pc, 32'h0000_0044);
    do_fetch(j40_w, 0);
    do_consume(2'b01, 1'b0, 1'b0, 32'd0);
    do_fetch(bne_w, 0);
    do_consume(2'b00, 1'b1, 1'b0, 32'd0);
    check_eq("bne_taken", pc, 32'h0000_003C);
    do_fetch(beq_w, 0);
    do_consume(2'b11, 1'b1, 1'b1, 32'd0);
    check_eq("jmp11_as_branch", pc, 32'h0000_0038);

    do_fetch(32'h0000_0008, 0);
    do_consume(2'b10, 1'b0, 1'b0, 32'h1000_0000);
    check_eq("jr_aligned_no_err", 32'(align_err), 32'd0);
    do_fetch(j40_w, 0);
    do_consume(2'b01, 1'b0, 1'b0, 32'd0);
    check_eq("j_region", pc, 32'h1000_0040);
    do_fetch(32'h0000_0008, 0);
    do_consume(2'b10, 1'b0, 1'b0, 32'h0000_0203);
    check_eq("jr_misaligned_pc", pc, 32'h0000_0200);
    check_eq("jr_misaligned_err", 32'(align_err), 32'd1);

    // Execute stall, with a stray imem_ready that must be ignored
    do_fetch(32'h0123_4567, 0);
    for (int c = 0; c < 5; c++) begin
      imem_ready = (c == 1);
      imem_rdata = 32'hFFFF_0000;
      tick();
      check_eq("stall_instr", instr, m_instr);
      check_eq("stall_pc", pc, m_pc);
      check_eq("stall_valid", 32'(instr_valid), 32'd1);
      check_eq("stall_retired", retired, m_retired);
      check_eq("stall_no_req", 32'(imem_req), 32'd0);
    end
    imem_ready = 1'b0;
    do_consume(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC);

    // Long memory stall, then sequential wrap past the top of memory
    do_fetch(32'h0000_0020, 16);
    do_consume(2'b00, 1'b0, 1'b0, 32'd0);
    check_eq("pc_wrap", pc, 32'h0000_0000);
    check_eq("fetch_err_sticky", 32'(fetch_err), 32'd1);

    // Reset during an outstanding request with ready arriving around it
    wait_fetch();
    pop_expected(ea_final);
    check_eq("pre_rst_addr", imem_addr, ea_final);
    rst = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_0001;
    #1;
    check_eq("async_rst_req", 32'(imem_req), 32'd0);
    check_eq("async_rst_pc", pc, 32'd0);
    tick();
    check_eq("rst_late_instr", instr, 32'd0);
    check_eq("rst_late_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_clr_fetch_err", 32'(fetch_err), 32'd0);
    check_eq("rst_clr_align_err", 32'(align_err), 32'd0);
    check_eq("rst_clr_retired", retired, 32'd0);
    rst = 1'b1;
    tick();
    imem_ready = 1'b0;
    check_eq("post_rst_instr", instr, 32'd0);
    check_eq("post_rst_valid", 32'(instr_valid), 32'd0);
    check_eq("post_rst_req", 32'(imem_req), 32'd1);
    check_eq("post_rst_addr", imem_addr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
